// File: rtl/data_arb_pkg.sv
// Shared types and helpers for the two-master data port arbiter.
package data_arb_pkg;

    typedef enum logic {
        MST_CORE = 1'b0,
        MST_TEST = 1'b1
    } master_id_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } lock_state_t;

    // Bits needed to hold a count from 0 up to and including max_count.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order queue of master IDs for granted-but-unanswered transactions.
module arb_id_fifo
    import data_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  master_id_t                    push_id_i,
    input  logic                          pop_i,
    output master_id_t                    head_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [cnt_width(DEPTH)-1:0]   count_o
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    master_id_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the count alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_id_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/data_port_arbiter.sv
// Round-robin arbiter sharing one OBI-style data port between the LSU and the
// self-test engine, routing in-order responses back to the issuing master.
module data_port_arbiter
    import data_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    m0_req_i,
    input  logic [ADDR_WIDTH-1:0]                   m0_addr_i,
    input  logic                                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0]                 m0_be_i,
    input  logic [DATA_WIDTH-1:0]                   m0_wdata_i,
    output logic                                    m0_gnt_o,
    output logic                                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]                   m0_rdata_o,
    input  logic                                    m1_req_i,
    input  logic [ADDR_WIDTH-1:0]                   m1_addr_i,
    input  logic                                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0]                 m1_be_i,
    input  logic [DATA_WIDTH-1:0]                   m1_wdata_i,
    output logic                                    m1_gnt_o,
    output logic                                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]                   m1_rdata_o,
    output logic                                    s_req_o,
    output logic [ADDR_WIDTH-1:0]                   s_addr_o,
    output logic                                    s_we_o,
    output logic [DATA_WIDTH/8-1:0]                 s_be_o,
    output logic [DATA_WIDTH-1:0]                   s_wdata_o,
    input  logic                                    s_gnt_i,
    input  logic                                    s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                   s_rdata_i,
    output logic [cnt_width(MAX_OUTSTANDING)-1:0]   outstanding_o,
    output logic                                    err_o
);

    lock_state_t lock_q, lock_d;
    master_id_t  lock_id_q, lock_id_d;
    master_id_t  ptr_q, ptr_d;
    logic        err_q, err_d;

    master_id_t  sel;
    logic        sel_req;
    logic        handshake;
    master_id_t  head_id;
    logic        fifo_full;
    logic        fifo_empty;
    logic        rsp_ok;

    // A held request keeps its master until granted, so the slave never sees
    // attributes change mid-request.
    always_comb begin
        sel = MST_CORE;
        if (lock_q == ARB_HOLD) begin
            sel = lock_id_q;
        end else if (m0_req_i && !m1_req_i) begin
            sel = MST_CORE;
        end else if (m1_req_i && !m0_req_i) begin
            sel = MST_TEST;
        end else if (m0_req_i && m1_req_i) begin
            sel = ptr_q;
        end
    end

    assign sel_req   = (sel == MST_TEST) ? m1_req_i : m0_req_i;
    assign s_req_o   = sel_req && !fifo_full && !rst_i;
    assign s_addr_o  = (sel == MST_TEST) ? m1_addr_i  : m0_addr_i;
    assign s_we_o    = (sel == MST_TEST) ? m1_we_i    : m0_we_i;
    assign s_be_o    = (sel == MST_TEST) ? m1_be_i    : m0_be_i;
    assign s_wdata_o = (sel == MST_TEST) ? m1_wdata_i : m0_wdata_i;

    assign handshake = s_req_o && s_gnt_i;
    assign m0_gnt_o  = handshake && (sel == MST_CORE);
    assign m1_gnt_o  = handshake && (sel == MST_TEST);

    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        ptr_d     = ptr_q;
        err_d     = err_q || (s_rvalid_i && fifo_empty);
        case (lock_q)
            ARB_IDLE: begin
                if (s_req_o && !s_gnt_i) begin
                    lock_d    = ARB_HOLD;
                    lock_id_d = sel;
                end
            end
            ARB_HOLD: begin
                if (s_gnt_i) begin
                    lock_d = ARB_IDLE;
                end
            end
            default: lock_d = ARB_IDLE;
        endcase
        if (handshake) begin
            ptr_d = (sel == MST_CORE) ? MST_TEST : MST_CORE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q    <= ARB_IDLE;
            lock_id_q <= MST_CORE;
            ptr_q     <= MST_CORE;
            err_q     <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (handshake),
        .push_id_i (sel),
        .pop_i     (rsp_ok),
        .head_o    (head_id),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (outstanding_o)
    );

    // A response with nothing outstanding is dropped and only flagged via err_o.
    assign rsp_ok      = s_rvalid_i && !fifo_empty;
    assign m0_rvalid_o = rsp_ok && (head_id == MST_CORE);
    assign m1_rvalid_o = rsp_ok && (head_id == MST_TEST);
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign err_o       = err_q;

endmodule

// File: doc/data_port_arbiter.md
Name: data_port_arbiter

Overview:
- Two-master to one-slave arbiter for the core-side OBI-style data bus (req/gnt address phase, in-order rvalid response phase).
- Shares the single mm_ram data port between the RI5CY LSU (master 0) and the self-test/loader engine (master 1).
- Uses round-robin address-phase arbitration and tracks outstanding transactions so each response is routed to the master that issued it.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, read/write data width; byte enable width is DATA_WIDTH/8
MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
m0_req_i / m1_req_i  in  1  master request
m0_addr_i / m1_addr_i  in  ADDR_WIDTH  address
m0_we_i / m1_we_i  in  1  write enable
m0_be_i / m1_be_i  in  DATA_WIDTH/8  byte enables
m0_wdata_i / m1_wdata_i  in  DATA_WIDTH  write data
m0_gnt_o / m1_gnt_o  out  1  address-phase grant
m0_rvalid_o / m1_rvalid_o  out  1  response valid
m0_rdata_o / m1_rdata_o  out  DATA_WIDTH  response data (s_rdata_i broadcast)
s_req_o  out  1  slave request
s_addr_o  out  ADDR_WIDTH  slave address
s_we_o  out  1  slave write enable
s_be_o  out  DATA_WIDTH/8  slave byte enables
s_wdata_o  out  DATA_WIDTH  slave write data
s_gnt_i  in  1  slave grant
s_rvalid_i  in  1  slave response valid
s_rdata_i  in  DATA_WIDTH  slave read data
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count
err_o  out  1  sticky: rvalid received with no outstanding transaction

Behaviour:
- Reset values (async on rst_i=1):
  - priority pointer = master 0
  - lock = none; ID FIFO empty; outstanding_o = 0; err_o = 0
  - all gnt/rvalid outputs 0 while rst_i=1
- Address phase is combinational, zero added latency:
  - Select the master, drive its addr/we/be/wdata onto s_*, and set s_req_o = selected req.
  - Route s_gnt_i only to the selected master's gnt; the other gnt = 0.
- Selection:
  - lock active -> locked master.
  - Otherwise, only one requester -> that master.
  - Otherwise, both requesting -> pointer master.
  - Neither requesting -> s_req_o = 0.
- Lock FSM (IDLE, HOLD):
  - IDLE->HOLD when s_req_o=1 & s_gnt_i=0; record the selected master.
  - HOLD->IDLE on s_gnt_i=1. Selection stays fixed while in HOLD, so the slave never sees request attributes change before grant.
- Pointer update: on handshake (s_req_o & s_gnt_i), the pointer moves to the master that was NOT granted.
- ID FIFO, depth MAX_OUTSTANDING:
  - Push the granted master ID on handshake; pop on s_rvalid_i.
  - Simultaneous push and pop are allowed and leave the count unchanged.
  - The pointer wraps modulo depth.
- Full: when outstanding_o == MAX_OUTSTANDING, s_req_o is forced 0 and both gnts are 0, even if s_rvalid_i arrives in that cycle. Issue resumes the following cycle.
  - HOLD cannot coincide with full, because the count rises only on grant.
- Response phase, combinational:
  - m<head>_rvalid_o = s_rvalid_i when the FIFO is non-empty.
  - Response order equals grant order.
- s_rvalid_i with empty FIFO: no master rvalid, the count stays 0, and err_o is set (sticky until reset).
- Reset mid-operation: outstanding IDs and lock are discarded. Later stray responses set err_o.
- Slave protocol assumption: rvalid arrives no earlier than the cycle after its grant.

Decomposition:
- Package data_arb_pkg holds:
  - typedef master_id_t (1-bit enum MST_CORE=0, MST_TEST=1)
  - lock state enum (ARB_IDLE, ARB_HOLD)
  - function for the count width
- Sub-module arb_id_fifo: parameterised-depth FIFO of master_id_t with push/pop/full/empty/count, same clk_i/rst_i.

Test Plan:
- m0 read 0x100, slave gnt immediately, rvalid next cycle with 0xDEADBEEF -> m0_gnt_o=1 cycle 0, m0_rvalid_o=1 with 0xDEADBEEF cycle 1, m1 untouched, outstanding_o 0->1->0.
- m0 and m1 both request continuously, slave always grants -> grants alternate m0,m1,m0,m1; response IDs match grant order.
- m1 requests addr 0x200 while s_gnt_i held 0 for 3 cycles, m0 raises req in cycle 1 -> s_addr_o stays 0x200 and only m1 is granted in cycle 3; m0 is granted next.
- MAX_OUTSTANDING=2, slave grants two m0 requests and withholds rvalid -> outstanding_o=2, s_req_o=0 and no gnt for a pending m1 until one rvalid arrives; issue resumes the following cycle.
- s_rvalid_i pulsed with FIFO empty -> no master rvalid, err_o=1 and held; rst_i pulse clears it to 0.
- rst_i asserted with 2 outstanding and HOLD active -> outstanding_o=0 and lock cleared immediately; the next request from m0 is selected by default priority.
